// File: rtl/xadc_multi_avg.sv
// Multi-channel XADC DRP reader with per-channel boxcar averaging over 2^AVG_LOG2 rounds.
// Optional hysteresis alarm on each new average is built only when XADC_ALARM_HYST_EN is defined.
module xadc_multi_avg #(
    parameter int                  NUM_CH      = 2,
    parameter logic [7*NUM_CH-1:0] CH_ADDRS    = {7'h16, 7'h00},
    parameter int                  AVG_LOG2    = 4,
    parameter int                  TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   eoc,
    output logic [6:0]             drp_daddr,
    output logic                   drp_den,
    output logic                   drp_dwe,
    output logic [15:0]            drp_di,
    input  logic [15:0]            drp_do,
    input  logic                   drp_drdy,
    output logic [12*NUM_CH-1:0]   avg_data,
    output logic                   avg_valid,
    output logic                   busy,
    output logic                   err_timeout,
    output logic [NUM_CH-1:0]      alarm,
    input  logic [11:0]            thresh_hi,
    input  logic [11:0]            thresh_lo
);

    localparam int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                RND_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int                ACC_W     = 12 + AVG_LOG2;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [RND_W-1:0]  LAST_RND  = RND_W'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]       LAST_TICK = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACC, S_OUT} state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   ch;
    logic [RND_W-1:0]  round;
    logic [15:0]       tick;
    logic [6:0]        daddr_q;
    logic [6:0]        cur_addr;
    logic              expired;
    logic [11:0]       sample [NUM_CH];
    logic [ACC_W-1:0]  acc    [NUM_CH];

    assign cur_addr  = CH_ADDRS[7*ch +: 7];
    assign expired   = (tick == LAST_TICK);
    assign drp_den   = (state == S_REQ);
    // The address is presented live in REQ and then held so it stays stable until the next request.
    assign drp_daddr = (state == S_REQ) ? cur_addr : daddr_q;
    assign drp_dwe   = 1'b0;
    assign drp_di    = 16'h0000;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (eoc) state_n = S_REQ;
            S_REQ:  state_n = S_WAIT;
            S_WAIT: begin
                if (drp_drdy)     state_n = (ch == LAST_CH) ? S_ACC : S_REQ;
                else if (expired) state_n = S_IDLE;
            end
            S_ACC:  state_n = (round == LAST_RND) ? S_OUT : S_IDLE;
            S_OUT:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ch          <= '0;
            round       <= '0;
            tick        <= '0;
            daddr_q     <= '0;
            avg_data    <= '0;
            avg_valid   <= 1'b0;
            err_timeout <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sample[i] <= '0;
                acc[i]    <= '0;
            end
        end else begin
            state     <= state_n;
            avg_valid <= (state == S_OUT);
            case (state)
                S_REQ: begin
                    tick    <= '0;
                    daddr_q <= cur_addr;
                end
                S_WAIT: begin
                    // A drdy landing on the expiry cycle still counts as a good read.
                    if (drp_drdy) begin
                        sample[ch] <= drp_do[15:4];
                        ch         <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                    end else if (expired) begin
                        err_timeout <= 1'b1;
                        ch          <= '0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_ACC: begin
                    for (int i = 0; i < NUM_CH; i++)
                        acc[i] <= acc[i] + ACC_W'(sample[i]);
                    round <= (round == LAST_RND) ? '0 : round + 1'b1;
                end
                S_OUT: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        avg_data[12*i +: 12] <= acc[i][AVG_LOG2 +: 12];
                        acc[i]               <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef XADC_ALARM_HYST_EN
    // Set wins over clear so an inverted threshold pair still raises the alarm.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm <= '0;
        end else if (state == S_OUT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i][AVG_LOG2 +: 12] > thresh_hi)
                    alarm[i] <= 1'b1;
                else if (acc[i][AVG_LOG2 +: 12] < thresh_lo)
                    alarm[i] <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^drp_do[3:0];
`else
    assign alarm = '0;

    logic unused_bits;
    assign unused_bits = ^{drp_do[3:0], thresh_hi, thresh_lo};
`endif

endmodule

// File: tb/tb_xadc_multi_avg.sv
// Randomised bench for xadc_multi_avg: DRP responder plus a round-level averaging scoreboard.
// Alarm expectations follow XADC_ALARM_HYST_EN, so the bench runs with the macro defined or not.
module tb_xadc_multi_avg;

    localparam int                NUM_CH      = 2;
    localparam int                AVG_LOG2    = 2;
    localparam int                TIMEOUT_CYC = 20;
    localparam int                DRDY_LAT    = 3;
    localparam logic [7*NUM_CH-1:0] CH_ADDRS  = {7'h16, 7'h00};
`ifdef XADC_ALARM_HYST_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    typedef struct {
        logic [12*NUM_CH-1:0] avg;
        logic [NUM_CH-1:0]    alm;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 eoc;
    logic [6:0]           drp_daddr;
    logic                 drp_den;
    logic                 drp_dwe;
    logic [15:0]          drp_di;
    logic [15:0]          drp_do = 16'h0000;
    logic                 drp_drdy = 1'b0;
    logic [12*NUM_CH-1:0] avg_data;
    logic                 avg_valid;
    logic                 busy;
    logic                 err_timeout;
    logic [NUM_CH-1:0]    alarm;
    logic [11:0]          thresh_hi;
    logic [11:0]          thresh_lo;

    xadc_multi_avg #(
        .NUM_CH(NUM_CH), .CH_ADDRS(CH_ADDRS), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .eoc(eoc),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .avg_data(avg_data), .avg_valid(avg_valid), .busy(busy), .err_timeout(err_timeout),
        .alarm(alarm), .thresh_hi(thresh_hi), .thresh_lo(thresh_lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_cmp++;
        if (obs !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, obs, expected);
        end
    endtask

    // Stimulus-side knobs, written only by the main sequence.
    logic [15:0] next_data [NUM_CH];
    int          withhold_at = -1;

    // Responder and reference-model state, written only by the negedge process.
    int          dly = 0;
    logic [15:0] pend = 16'h0000;
    int          pend_ch = 0;
    logic [11:0] round_samp [NUM_CH];
    int          round_got = 0;
    int          sum [NUM_CH];
    int          rounds_ok = 0;
    logic [NUM_CH-1:0] alarm_model = '0;
    exp_t        exp_q [$];
    exp_t        sb_e;
    int          den_count = 0;
    int          busy_rises = 0;
    int          valid_count = 0;
    int          exp_count = 0;
    logic        busy_prev = 1'b0;
    logic [6:0]  addr_log [$];

    function automatic int addrToCh(input logic [6:0] a);
        for (int i = 0; i < NUM_CH; i++)
            if (CH_ADDRS[7*i +: 7] == a) return i;
        return 0;
    endfunction

    // A complete round contributes one sample per channel; every 2^AVG_LOG2 of them yield an average.
    task automatic commitRound();
        int a;
        for (int c = 0; c < NUM_CH; c++) sum[c] += int'(round_samp[c]);
        rounds_ok++;
        if (rounds_ok == (1 << AVG_LOG2)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                a = sum[c] / (1 << AVG_LOG2);
                sb_e.avg[12*c +: 12] = 12'(a);
                if (ALM_EN) begin
                    if (a > int'(thresh_hi))      alarm_model[c] = 1'b1;
                    else if (a < int'(thresh_lo)) alarm_model[c] = 1'b0;
                end
                sum[c] = 0;
            end
            sb_e.alm  = alarm_model;
            rounds_ok = 0;
            exp_q.push_back(sb_e);
            exp_count++;
        end
    endtask

    always @(negedge clk) begin
        drp_drdy = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                drp_drdy = 1'b1;
                drp_do   = pend;
                round_samp[pend_ch] = pend[15:4];
                round_got++;
            end
        end
        if (drp_den) begin
            den_count++;
            addr_log.push_back(drp_daddr);
            pend_ch = addrToCh(drp_daddr);
            if (den_count != withhold_at) begin
                dly  = DRDY_LAT;
                pend = next_data[pend_ch];
            end
        end
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) sum[c] = 0;
            rounds_ok   = 0;
            alarm_model = '0;
            exp_q.delete();
        end else begin
            if (busy && !busy_prev) begin
                busy_rises++;
                round_got = 0;
            end
            if (!busy && busy_prev && round_got == NUM_CH) commitRound();
        end
        if (avg_valid) begin
            valid_count++;
            checkOutput("valid_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                checkOutput("avg_data", 32'(avg_data), 32'(sb_e.avg));
                checkOutput("alarm", 32'(alarm), 32'(sb_e.alm));
            end
        end
        busy_prev = busy;
    end

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] d0, input logic [15:0] d1, input bit hold_ch1);
        next_data[0] = d0;
        next_data[1] = d1;
        withhold_at  = hold_ch1 ? den_count + 2 : -1;
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        waitIdle();
        withhold_at = -1;
    endtask

    task automatic applyReset();
        eoc   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_avg_data"}, 32'(avg_data), 0);
        checkOutput({tag, "_avg_valid"}, 32'(avg_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_err"}, 32'(err_timeout), 0);
        checkOutput({tag, "_alarm"}, 32'(alarm), 0);
        checkOutput({tag, "_den"}, 32'(drp_den), 0);
        checkOutput({tag, "_daddr"}, 32'(drp_daddr), 0);
    endtask

    initial begin
        int v0, b0, d0, n;
        reset = 1'b1;
        eoc = 1'b0;
        thresh_hi = 12'h800;
        thresh_lo = 12'h700;
        next_data[0] = 16'h0000;
        next_data[1] = 16'h0000;

        applyReset();
        checkIdleOutputs("reset");
        checkOutput("reset_dwe", 32'(drp_dwe), 0);
        checkOutput("reset_di", 32'(drp_di), 0);

        // Fixed data: one average after four rounds, addresses alternate per round.
        addr_log.delete();
        repeat (4) applyStimulus(16'h8000, 16'h4010, 1'b0);
        checkOutput("fixed_valids", 32'(valid_count), 1);
        checkOutput("fixed_avg", 32'(avg_data), 32'h401800);
        checkOutput("addr_count", 32'(addr_log.size()), 2 * 4);
        for (int i = 0; i < addr_log.size(); i++)
            checkOutput("addr_seq", 32'(addr_log[i]), (i % 2 == 0) ? 32'h00 : 32'h16);

        // Truncation: 0,1,2,3 averages to 1.
        for (int i = 0; i < 4; i++) applyStimulus(16'(i * 16), 16'($urandom), 1'b0);
        checkOutput("trunc_ch0", 32'(avg_data[11:0]), 32'h001);

        // Aborted round: no average until four good rounds, aborted samples excluded.
        v0 = valid_count;
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        applyStimulus(16'hFFF0, 16'hFFF0, 1'b1);
        checkOutput("err_timeout_set", 32'(err_timeout), 1);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        checkOutput("abort_no_valid", 32'(valid_count - v0), 0);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        checkOutput("abort_one_valid", 32'(valid_count - v0), 1);
        checkOutput("err_timeout_sticky", 32'(err_timeout), 1);

        // Alarm hysteresis on ch0: above hi, between, below lo.
        repeat (4) applyStimulus(16'h9000, 16'($urandom), 1'b0);
        checkOutput("alarm_high", 32'(alarm[0]), 32'(ALM_EN));
        repeat (4) applyStimulus(16'h7800, 16'($urandom), 1'b0);
        checkOutput("alarm_hold", 32'(alarm[0]), 32'(ALM_EN));
        repeat (4) applyStimulus(16'h6000, 16'($urandom), 1'b0);
        checkOutput("alarm_clear", 32'(alarm[0]), 0);

        // Random rounds, scoreboard checks each average.
        repeat (8) applyStimulus(16'($urandom), 16'($urandom), 1'b0);

        // eoc held high: busy periods each issue exactly NUM_CH requests.
        applyReset();
        b0 = busy_rises;
        d0 = den_count;
        next_data[0] = 16'($urandom);
        next_data[1] = 16'($urandom);
        eoc = 1'b1;
        repeat (40) @(negedge clk);
        eoc = 1'b0;
        waitIdle();
        checkOutput("eoc_rounds_min", 32'((busy_rises - b0) >= 3), 1);
        checkOutput("den_per_round", 32'(den_count - d0), 32'(NUM_CH * (busy_rises - b0)));

        // Reset during WAIT with drdy arriving the cycle after.
        eoc = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!drp_den && n < 20);
        eoc = 1'b0;
        checkOutput("rst_wait_den_seen", 32'(drp_den), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkIdleOutputs("rst_wait");
        @(negedge clk);
        checkOutput("rst_wait_busy_after_drdy", 32'(busy), 0);
        repeat (4) applyStimulus(16'($urandom), 16'($urandom), 1'b0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
        checkOutput("valid_total", 32'(valid_count), 32'(exp_count));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/xadc_multi_avg.md
Name: xadc_multi_avg

Overview:
- Parametrised successor to the single-channel XADC readout.
- Drives the XADC DRP port directly and reads NUM_CH status-register addresses in sequence on every end-of-conversion.
- Boxcar-averages each channel over 2^AVG_LOG2 complete rounds and presents all averages on one flat bus with a one-cycle valid strobe.
- Sits between xadc_wiz_0 and the top-level LED/display logic. All timing is in clk; nothing is clocked on drdy.

Parameters:
- NUM_CH, 2, number of channels read per round (1..8).
- CH_ADDRS, {7'h16,7'h00}, packed DRP addresses, 7 bits each; channel i = CH_ADDRS[7*i+:7]. Default: ch0 = temperature, ch1 = VAUX6.
- AVG_LOG2, 4, log2 of rounds averaged (0..8; 0 = no averaging).
- TIMEOUT_CYC, 255, clk cycles to wait for drdy before aborting the round (1..65535).

Ports:
- clk  in  1  system clock (100 MHz), also XADC dclk_in.
- reset  in  1  synchronous, active-high.
- eoc  in  1  XADC eoc_out.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  constant 0.
- drp_di  out  16  constant 0.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP data ready.
- avg_data  out  12*NUM_CH  channel i average at [12*i+:12].
- avg_valid  out  1  one-cycle pulse when avg_data updates.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_timeout  out  1  sticky; cleared only by reset.
- alarm  out  NUM_CH  per-channel threshold alarm (see Optional Feature).
- thresh_hi  in  12  alarm set level.
- thresh_lo  in  12  alarm clear level.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FSM to IDLE; channel index, round counter, sample registers and accumulators all 0. Reset mid-transaction abandons it; a late drp_drdy is ignored because the FSM is in IDLE.
- Sample: 12-bit value = drp_do[15:4].
- IDLE: eoc=1 at edge k -> REQ. eoc seen in any other state is ignored, no error.
- REQ (one cycle): drp_den=1, drp_daddr=CH_ADDRS[ch]; load timeout counter; -> WAIT. drp_daddr holds its value until the next REQ.
- WAIT:
  - drp_drdy=1: store sample[ch].
  - If ch < NUM_CH-1: ch++ and -> REQ.
  - Otherwise: ch=0 and -> ACC.
  - Timeout counter reaching TIMEOUT_CYC with no drdy: err_timeout=1, discard all samples of this round (accumulators untouched, round counter not advanced), ch=0, -> IDLE.
  - drdy arriving in the same cycle as expiry: drdy wins.
- ACC (one cycle): acc[i] += sample[i] for every channel; acc width 12+AVG_LOG2, which cannot overflow. round++.
  - If round wraps to 0: -> OUT.
  - Otherwise: -> IDLE.
- OUT (one cycle): avg_data[i] = acc[i] >> AVG_LOG2 (truncating); acc[i]=0; avg_valid=1 during the following cycle; -> IDLE.
- Latency: eoc at edge k -> first drp_den during cycle k+1. With drdy latency D, a round takes NUM_CH*(D+1)+1 cycles after REQ. avg_valid follows the final ACC by 2 cycles.
- avg_data holds its value between updates.

Optional Feature:
- Macro: XADC_ALARM_HYST_EN.
- Defined: at each OUT, alarm[i] sets when the new average > thresh_hi and clears when it is < thresh_lo; otherwise alarm[i] holds. If thresh_lo > thresh_hi, the set condition takes priority.
- Undefined: alarm is tied to 0 and no compare logic is built.

Test Plan (NUM_CH=2, AVG_LOG2=2, TIMEOUT_CYC=20, DRP model drdy 3 cycles after den unless stated):
- Reset, then 4 eoc pulses; ch0 returns 16'h8000, ch1 returns 16'h4010 -> daddr sequence 00,16 per round; one avg_valid after round 4; avg_data = {12'h401,12'h800}.
- ch0 returns 16'h0000, 16'h0010, 16'h0020, 16'h0030 over 4 rounds -> ch0 average = (0+1+2+3)>>2 = 12'h001 (truncated).
- DRP model withholds drdy on round 2 ch1 -> err_timeout=1 after 20 cycles; no avg_valid until 4 successful rounds have completed; averages exclude the aborted round's samples.
- eoc pulsed every cycle -> exactly one den per channel per round; eoc pulses during busy ignored.
- Reset asserted while in WAIT, drdy arrives next cycle -> all outputs 0, FSM in IDLE, sample not stored.
- With XADC_ALARM_HYST_EN, thresh_hi=12'h800, thresh_lo=12'h700:
  - Averages 12'h900 -> alarm[0]=1.
  - Then 12'h780 -> alarm stays 1.
  - Then 12'h600 -> alarm=0.
  - Same stimulus without the macro -> alarm=0 throughout.
